// File: rtl/store_queue.sv
// Store queue: in-order allocation, out-of-order execute, in-order commit and
// drain to the D-cache, plus store-to-load forwarding for younger loads.
module store_queue #(
  parameter int SQ_DEPTH = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        disp_en,
  output logic [$clog2(SQ_DEPTH)-1:0] disp_idx,
  output logic                        sq_full,
  input  logic                        exe_en,
  input  logic [$clog2(SQ_DEPTH)-1:0] exe_idx,
  input  logic [31:0]                 exe_addr,
  input  logic [31:0]                 exe_data,
  input  logic [1:0]                  exe_size,
  input  logic [31:0]                 ld_addr,
  input  logic [1:0]                  ld_size,
  input  logic [$clog2(SQ_DEPTH)-1:0] ld_tail,
  output logic                        ld_fwd_hit,
  output logic [31:0]                 ld_fwd_data,
  output logic                        ld_stall,
  input  logic [1:0]                  rt_cnt,
  input  logic                        squash,
  output logic                        mem_wr_en,
  output logic [31:0]                 mem_wr_addr,
  output logic [31:0]                 mem_wr_data,
  output logic [1:0]                  mem_wr_size,
  input  logic                        mem_wr_ack
);

  localparam int IDX_W = $clog2(SQ_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] base;
    case (size)
      2'd0:    base = 4'b0001;
      2'd1:    base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << off;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  function automatic logic [31:0] lane_align(input logic [31:0] data, input logic [1:0] off);
    return data << {off, 3'b000};
  endfunction

  logic [PTR_W-1:0]    head_q, commit_q, tail_q;
  logic [PTR_W-1:0]    commit_nxt, occ;
  logic [SQ_DEPTH-1:0] addr_valid_q;
  logic [31:0]         addr_q [SQ_DEPTH];
  logic [31:0]         data_q [SQ_DEPTH];
  logic [1:0]          size_q [SQ_DEPTH];

  logic [IDX_W-1:0] head_idx, tail_idx, exe_off;
  logic             disp_ok, exe_ok, pop;

  assign head_idx   = head_q[IDX_W-1:0];
  assign tail_idx   = tail_q[IDX_W-1:0];
  assign occ        = tail_q - head_q;
  assign exe_off    = exe_idx - head_idx;
  assign commit_nxt = commit_q + PTR_W'(rt_cnt);

  assign sq_full  = (tail_idx == head_idx) && (tail_q[IDX_W] != head_q[IDX_W]);
  assign disp_idx = tail_idx;
  assign disp_ok  = disp_en && !sq_full && !squash;
  // Only entries currently between head and tail may be executed.
  assign exe_ok   = exe_en && !squash && ({1'b0, exe_off} < occ);

  assign mem_wr_en   = (head_q != commit_q) && addr_valid_q[head_idx];
  assign mem_wr_addr = addr_q[head_idx];
  assign mem_wr_data = data_q[head_idx];
  assign mem_wr_size = size_q[head_idx];
  assign pop         = mem_wr_en && mem_wr_ack;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q       <= '0;
      commit_q     <= '0;
      tail_q       <= '0;
      addr_valid_q <= '0;
    end else begin
      if (pop) head_q <= head_q + PTR_W'(1);
      commit_q <= commit_nxt;
      // Squash rewinds tail to the post-retire commit point.
      if (squash)       tail_q <= commit_nxt;
      else if (disp_ok) tail_q <= tail_q + PTR_W'(1);
      if (disp_ok) addr_valid_q[tail_idx] <= 1'b0;
      if (exe_ok)  addr_valid_q[exe_idx]  <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (exe_ok) begin
      addr_q[exe_idx] <= exe_addr;
      data_q[exe_idx] <= exe_data;
      size_q[exe_idx] <= exe_size;
    end
  end

  logic [3:0]       ld_mask, st_mask, sel_mask;
  logic [IDX_W-1:0] ld_cnt, ent;
  logic [31:0]      sel_data;
  logic             unknown, found;

  // Walk oldest to youngest so the last overlapping entry wins.
  always_comb begin
    ld_mask     = byte_mask(ld_size, ld_addr[1:0]);
    ld_cnt      = ld_tail - head_idx;
    st_mask     = '0;
    ent         = '0;
    sel_mask    = '0;
    sel_data    = '0;
    unknown     = 1'b0;
    found       = 1'b0;
    ld_fwd_hit  = 1'b0;
    ld_stall    = 1'b0;
    ld_fwd_data = '0;
    for (int k = 0; k < SQ_DEPTH; k++) begin
      ent = head_idx + IDX_W'(k);
      if (IDX_W'(k) < ld_cnt) begin
        if (!addr_valid_q[ent]) unknown = 1'b1;
        st_mask = byte_mask(size_q[ent], addr_q[ent][1:0]);
        if ((addr_q[ent][31:2] == ld_addr[31:2]) && ((st_mask & ld_mask) != 4'b0000)) begin
          found    = 1'b1;
          sel_mask = st_mask;
          sel_data = lane_align(data_q[ent], addr_q[ent][1:0]) & lane_mask(st_mask);
        end
      end
    end
    if (unknown) begin
      ld_stall = 1'b1;
    end else if (found) begin
      if ((sel_mask & ld_mask) == ld_mask) begin
        ld_fwd_hit  = 1'b1;
        ld_fwd_data = sel_data;
      end else begin
        ld_stall = 1'b1;
      end
    end
  end

endmodule
